if_align_queue: RTL and testbench
=================================

IF_ALIGN_QUEUE -- requirements
Module: if_align_queue

Interface
REQ-001 SHALL have parameter FETCH_W, default 32, meaning fetch beat width in bits (legal values 32, 64, 128).
REQ-002 SHALL have parameter PARCELS, default 8, meaning queue capacity in 16-bit parcels (power of 2, at least 2*FETCH_W/16).
REQ-003 SHALL have port clk  input  1  meaning the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, which is synchronous and active-high.
REQ-005 SHALL have port flush_i  input  1  meaning discard all queued parcels (redirect).
REQ-006 SHALL have port fe_valid_i  input  1  meaning a fetch beat is offered.
REQ-007 SHALL have port fe_ready_o  output  1  meaning the queue accepts the beat.
REQ-008 SHALL have port fe_pc_i  input  32  meaning the byte address of the first useful parcel in the beat (halfword aligned).
REQ-009 SHALL have port fe_data_i  input  FETCH_W  meaning beat data, with parcel k at bits [16k+15:16k].
REQ-010 SHALL have port fe_fault_i  input  1  meaning an instruction page fault applies to the whole beat.
REQ-011 SHALL have port inst_valid_o  output  1  meaning an aligned instruction is available.
REQ-012 SHALL have port inst_ready_i  input  1  meaning the consumer takes the instruction.
REQ-013 SHALL have port inst_pc_o  output  32  meaning the instruction PC.
REQ-014 SHALL have port inst_data_o  output  32  meaning the raw instruction, {16'b0, parcel} when compressed (not expanded).
REQ-015 SHALL have port inst_is_rvc_o  output  1  meaning the instruction is 16-bit (low parcel [1:0] != 2'b11).
REQ-016 SHALL have port inst_fault_o  output  1  meaning the instruction carries a page fault.

Function
REQ-017 SHALL store parcels in a circular buffer with head/tail pointers and an occupancy count of width log2(PARCELS)+1; pointers wrap modulo PARCELS.
REQ-018 SHALL store a fault bit alongside each parcel.
REQ-019 SHALL drive fe_ready_o = (PARCELS - count) >= FETCH_W/16, computed from registered count only, with no combinational path from inst_ready_i.
REQ-020 SHALL treat fe_valid_i & fe_ready_o as a push; on a push the parcels from index fe_pc_i[log2(FETCH_W/8)-1:1] up to FETCH_W/16-1 SHALL be enqueued and lower parcels dropped.
REQ-021 SHALL maintain state NEED_PC (after reset/flush) and RUN: in NEED_PC the first push loads head_pc <= fe_pc_i and moves to RUN; in RUN pushed beats SHALL be contiguous and fe_pc_i is ignored.
REQ-022 SHALL assert inst_valid_o when count>=1 and either the head parcel is compressed, the head parcel is faulted, or count>=2.
REQ-023 SHALL form a 32-bit instruction as {parcel[head+1], parcel[head]}, including when the two parcels came from different beats or wrap the buffer.
REQ-024 SHALL set inst_fault_o if any consumed parcel is faulted; a faulted head parcel SHALL be issued alone as a 16-bit slot with inst_data_o = 0.
REQ-025 SHALL treat inst_valid_o & inst_ready_i as a pop: remove 1 or 2 parcels and advance head_pc by 2 or 4 with modulo-2^32 wrap.
REQ-026 SHALL allow a push and a pop in the same cycle, updating count by pushed minus popped parcels.
REQ-027 SHALL have latency such that a beat pushed in cycle N is visible at the outputs in cycle N+1; outputs are driven from registers through combinational muxes only.
REQ-028 SHALL give flush_i priority over a same-cycle push and pop: count 0, pointers 0, NEED_PC, beat discarded, inst_valid_o=0 next cycle.
REQ-029 SHALL hold all outputs stable while inst_valid_o=1 and inst_ready_i=0.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, set count, head, tail and head_pc to 0, enter NEED_PC, and give outputs inst_valid_o=0, fe_ready_o=1, inst_pc_o=0, inst_data_o=0, inst_is_rvc_o=0, inst_fault_o=0; reset overrides flush_i and any handshake.

Verification (FETCH_W=32, PARCELS=8)
REQ-031 SHALL cover: after reset, push pc 0x80000000 data 0x00000413 -> next cycle valid, pc 0x80000000, data 0x00000413, rvc=0.
REQ-032 SHALL cover: push pc 0x100 data 0x45014501 -> two instructions at pc 0x100 and 0x102, each with data 0x00004501 and rvc=1.
REQ-033 SHALL cover: push 0x100/0x04134501 then 0x104/0x45010000 -> pc 0x100 rvc 0x4501; pc 0x102 data 0x00000413; pc 0x106 rvc 0x4501.
REQ-034 SHALL cover: flush, then push pc 0x202 data 0x4501ABCD -> exactly one instruction, pc 0x202, data 0x00004501.
REQ-035 SHALL cover: inst_ready_i=0, push four beats -> fe_ready_o=0 after the 4th beat, count=8; one 32-bit pop -> fe_ready_o=1 next cycle.
REQ-036 SHALL cover: flush_i coincident with push and pop -> queue empty and inst_valid_o=0 next cycle; a beat with fe_fault_i=1 -> inst_fault_o=1 at its PC.

Source files
------------

// File: rtl/if_align_queue.sv
// Instruction-fetch alignment queue: buffers 16-bit parcels from fetch beats and
// presents one aligned 32-bit or compressed instruction per consumer handshake.
module if_align_queue #(
    parameter int FETCH_W = 32,
    parameter int PARCELS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               fe_valid_i,
    output logic               fe_ready_o,
    input  logic [31:0]        fe_pc_i,
    input  logic [FETCH_W-1:0] fe_data_i,
    input  logic               fe_fault_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [31:0]        inst_pc_o,
    output logic [31:0]        inst_data_o,
    output logic               inst_is_rvc_o,
    output logic               inst_fault_o
);
    localparam int BEAT_P = FETCH_W / 16;
    localparam int PW     = $clog2(PARCELS);
    localparam int CW     = PW + 1;
    localparam int OFF_W  = $clog2(BEAT_P);

    localparam logic [CW-1:0] BEAT_CNT  = CW'(BEAT_P);
    localparam logic [CW-1:0] READY_MAX = CW'(PARCELS - BEAT_P);

    typedef enum logic {NEED_PC, RUN} state_e;

    state_e                    state_q, state_d;
    logic [CW-1:0]             count_q, count_d;
    logic [PW-1:0]             head_q, head_d;
    logic [PW-1:0]             tail_q, tail_d;
    logic [31:0]               head_pc_q, head_pc_d;
    logic [PARCELS-1:0][15:0]  parcel_q, parcel_d;
    logic [PARCELS-1:0]        pfault_q, pfault_d;

    logic [PW-1:0]      head_nxt;
    logic [15:0]        lo_parcel, hi_parcel;
    logic               lo_fault, hi_fault, lo_rvc, pop_two;
    logic               push, pop;
    logic [OFF_W-1:0]   push_off;
    logic [CW-1:0]      push_n, pop_n;
    logic [FETCH_W-1:0] beat_shift;

    // Issue side: everything here depends only on registered state.
    always_comb begin
        head_nxt  = head_q + 1'b1;
        lo_parcel = parcel_q[head_q];
        hi_parcel = parcel_q[head_nxt];
        lo_fault  = pfault_q[head_q];
        hi_fault  = pfault_q[head_nxt];
        lo_rvc    = (lo_parcel[1:0] != 2'b11);
        // A faulted head is retired on its own so the fault lands on its exact PC.
        pop_two   = !lo_fault && !lo_rvc;

        inst_valid_o  = (count_q != '0) && (lo_rvc || lo_fault || (count_q >= CW'(2)));
        inst_pc_o     = head_pc_q;
        inst_is_rvc_o = inst_valid_o && !pop_two;
        inst_fault_o  = inst_valid_o && (lo_fault || (pop_two && hi_fault));
        inst_data_o   = '0;
        if (inst_valid_o && !lo_fault) begin
            inst_data_o = pop_two ? {hi_parcel, lo_parcel} : {16'h0000, lo_parcel};
        end

        fe_ready_o = (count_q <= READY_MAX);
        push       = fe_valid_i && fe_ready_o;
        pop        = inst_valid_o && inst_ready_i;
        pop_n      = pop_two ? CW'(2) : CW'(1);
    end

    // Fill side: the first beat after a redirect may start mid-beat.
    always_comb begin
        push_off   = (state_q == NEED_PC) ? fe_pc_i[OFF_W:1] : '0;
        push_n     = BEAT_CNT - CW'(push_off);
        beat_shift = fe_data_i >> {push_off, 4'b0000};

        parcel_d = parcel_q;
        pfault_d = pfault_q;
        if (push && !flush_i) begin
            for (int k = 0; k < BEAT_P; k++) begin
                if (CW'(k) < push_n) begin
                    parcel_d[tail_q + PW'(k)] = beat_shift[16*k +: 16];
                    pfault_d[tail_q + PW'(k)] = fe_fault_i;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;
        head_pc_d = head_pc_q;
        if (flush_i) begin
            state_d = NEED_PC;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + push_n[PW-1:0];
                if (state_q == NEED_PC) begin
                    state_d   = RUN;
                    head_pc_d = fe_pc_i;
                end
            end
            if (pop) begin
                head_d    = head_q + pop_n[PW-1:0];
                head_pc_d = head_pc_q + (pop_two ? 32'd4 : 32'd2);
            end
            count_d = count_q + (push ? push_n : '0) - (pop ? pop_n : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= NEED_PC;
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            head_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            head_pc_q <= head_pc_d;
        end
    end

    // Parcel storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        parcel_q <= parcel_d;
        pfault_q <= pfault_d;
    end

endmodule

// File: tb/tb_if_align_queue.sv
// Bench for if_align_queue: directed vector table followed by a randomized run
// against a parcel-queue reference model.
module tb_if_align_queue;
    localparam int FETCH_W = 32;
    localparam int PARCELS = 8;

    logic               clk = 1'b0;
    logic               rst, flush_i, fe_valid_i, fe_fault_i, inst_ready_i;
    logic [31:0]        fe_pc_i;
    logic [FETCH_W-1:0] fe_data_i;
    logic               fe_ready_o, inst_valid_o, inst_is_rvc_o, inst_fault_o;
    logic [31:0]        inst_pc_o, inst_data_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_align_queue #(.FETCH_W(FETCH_W), .PARCELS(PARCELS)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .fe_valid_i   (fe_valid_i),
        .fe_ready_o   (fe_ready_o),
        .fe_pc_i      (fe_pc_i),
        .fe_data_i    (fe_data_i),
        .fe_fault_i   (fe_fault_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_pc_o    (inst_pc_o),
        .inst_data_o  (inst_data_o),
        .inst_is_rvc_o(inst_is_rvc_o),
        .inst_fault_o (inst_fault_o)
    );

    // One row per cycle: outputs expected during the cycle, inputs driven in it.
    typedef struct packed {
        logic        fl, fv;
        logic [31:0] pc, data;
        logic        flt, rdy;
        logic        ev, er;
        logic [31:0] epc;
        logic        cpc;
        logic [31:0] ed;
        logic        erv, ef;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic        f;
    } parcel_t;

    function automatic vec_t mk(input logic fl, fv, input logic [31:0] pc, data,
                                input logic flt, rdy, ev, er, input logic [31:0] epc,
                                input logic cpc, input logic [31:0] ed, input logic erv, ef);
        vec_t v;
        v.fl = fl; v.fv = fv; v.pc = pc; v.data = data; v.flt = flt; v.rdy = rdy;
        v.ev = ev; v.er = er; v.epc = epc; v.cpc = cpc; v.ed = ed; v.erv = erv; v.ef = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, er, input logic [31:0] epc,
                              input logic cpc, input logic [31:0] ed, input logic erv, ef);
        chk({tag, ".valid"}, 32'(inst_valid_o), 32'(ev));
        chk({tag, ".fe_ready"}, 32'(fe_ready_o), 32'(er));
        if (cpc) chk({tag, ".pc"}, inst_pc_o, epc);
        chk({tag, ".data"}, inst_data_o, ed);
        chk({tag, ".rvc"}, 32'(inst_is_rvc_o), 32'(erv));
        chk({tag, ".fault"}, 32'(inst_fault_o), 32'(ef));
    endtask

    task automatic drive(input logic fl, fv, input logic [31:0] pc, data, input logic flt, rdy);
        flush_i      = fl;
        fe_valid_i   = fv;
        fe_pc_i      = pc;
        fe_data_i    = data;
        fe_fault_i   = flt;
        inst_ready_i = rdy;
    endtask

    initial begin
        vec_t        tbl[31];
        parcel_t     mq[$];
        parcel_t     pl;
        logic        need_pc;
        logic [31:0] mpc;
        logic        ev, er, erv, ef;
        logic [31:0] ed;
        int          n, off;

        //          fl fv pc            data          flt rdy  ev er epc           cpc ed            rvc f
        tbl[0]  = mk(0, 1, 32'h80000000, 32'h00000413, 0, 1,   0, 1, 32'h00000000, 1, 32'h00000000, 0, 0);
        tbl[1]  = mk(0, 0, 32'h0,        32'h0,        0, 1,   1, 1, 32'h80000000, 1, 32'h00000413, 0, 0);
        tbl[2]  = mk(1, 0, 32'h0,        32'h0,        0, 0,   0, 1, 32'h80000004, 1, 32'h00000000, 0, 0);
        tbl[3]  = mk(0, 1, 32'h00000100, 32'h45014501, 0, 1,   0, 1, 32'h0,        0, 32'h00000000, 0, 0);
        tbl[4]  = mk(0, 0, 32'h0,        32'h0,        0, 1,   1, 1, 32'h00000100, 1, 32'h00004501, 1, 0);
        tbl[5]  = mk(0, 0, 32'h0,        32'h0,        0, 1,   1, 1, 32'h00000102, 1, 32'h00004501, 1, 0);
        tbl[6]  = mk(1, 0, 32'h0,        32'h0,        0, 0,   0, 1, 32'h00000104, 1, 32'h00000000, 0, 0);
        tbl[7]  = mk(0, 1, 32'h00000100, 32'h04134501, 0, 0,   0, 1, 32'h0,        0, 32'h00000000, 0, 0);
        tbl[8]  = mk(0, 1, 32'h00000104, 32'h45010000, 0, 1,   1, 1, 32'h00000100, 1, 32'h00004501, 1, 0);
        tbl[9]  = mk(0, 0, 32'h0,        32'h0,        0, 1,   1, 1, 32'h00000102, 1, 32'h00000413, 0, 0);
        tbl[10] = mk(0, 0, 32'h0,        32'h0,        0, 1,   1, 1, 32'h00000106, 1, 32'h00004501, 1, 0);
        tbl[11] = mk(1, 0, 32'h0,        32'h0,        0, 0,   0, 1, 32'h00000108, 1, 32'h00000000, 0, 0);
        tbl[12] = mk(0, 1, 32'h00000202, 32'h4501ABCD, 0, 1,   0, 1, 32'h0,        0, 32'h00000000, 0, 0);
        tbl[13] = mk(0, 0, 32'h0,        32'h0,        0, 1,   1, 1, 32'h00000202, 1, 32'h00004501, 1, 0);
        tbl[14] = mk(0, 0, 32'h0,        32'h0,        0, 0,   0, 1, 32'h00000204, 1, 32'h00000000, 0, 0);
        tbl[15] = mk(0, 1, 32'h00000204, 32'h00000413, 0, 0,   0, 1, 32'h00000204, 1, 32'h00000000, 0, 0);
        tbl[16] = mk(0, 1, 32'h00000208, 32'h00000413, 0, 0,   1, 1, 32'h00000204, 1, 32'h00000413, 0, 0);
        tbl[17] = mk(0, 1, 32'h0000020C, 32'h00000413, 0, 0,   1, 1, 32'h00000204, 1, 32'h00000413, 0, 0);
        tbl[18] = mk(0, 1, 32'h00000210, 32'h00000413, 0, 0,   1, 1, 32'h00000204, 1, 32'h00000413, 0, 0);
        tbl[19] = mk(0, 1, 32'h00000214, 32'h11111111, 0, 1,   1, 0, 32'h00000204, 1, 32'h00000413, 0, 0);
        tbl[20] = mk(0, 0, 32'h0,        32'h0,        0, 0,   1, 1, 32'h00000208, 1, 32'h00000413, 0, 0);
        tbl[21] = mk(1, 1, 32'h00000300, 32'h45014501, 0, 1,   1, 1, 32'h00000208, 1, 32'h00000413, 0, 0);
        tbl[22] = mk(0, 1, 32'h00000400, 32'h00000413, 1, 0,   0, 1, 32'h0,        0, 32'h00000000, 0, 0);
        tbl[23] = mk(0, 0, 32'h0,        32'h0,        0, 1,   1, 1, 32'h00000400, 1, 32'h00000000, 1, 1);
        tbl[24] = mk(0, 0, 32'h0,        32'h0,        0, 1,   1, 1, 32'h00000402, 1, 32'h00000000, 1, 1);
        tbl[25] = mk(1, 0, 32'h0,        32'h0,        0, 0,   0, 1, 32'h00000404, 1, 32'h00000000, 0, 0);
        tbl[26] = mk(0, 1, 32'h00000502, 32'h0413ABCD, 0, 1,   0, 1, 32'h0,        0, 32'h00000000, 0, 0);
        tbl[27] = mk(0, 1, 32'h0,        32'h00000000, 1, 1,   0, 1, 32'h00000502, 1, 32'h00000000, 0, 0);
        tbl[28] = mk(0, 0, 32'h0,        32'h0,        0, 1,   1, 1, 32'h00000502, 1, 32'h00000413, 0, 1);
        tbl[29] = mk(0, 0, 32'h0,        32'h0,        0, 1,   1, 1, 32'h00000506, 1, 32'h00000000, 1, 1);
        tbl[30] = mk(1, 0, 32'h0,        32'h0,        0, 0,   0, 1, 32'h00000508, 1, 32'h00000000, 0, 0);

        rst = 1'b1;
        drive(0, 0, 32'h0, '0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 31; i++) begin
            check_outs($sformatf("row%0d", i), tbl[i].ev, tbl[i].er, tbl[i].epc, tbl[i].cpc,
                       tbl[i].ed, tbl[i].erv, tbl[i].ef);
            drive(tbl[i].fl, tbl[i].fv, tbl[i].pc, tbl[i].data, tbl[i].flt, tbl[i].rdy);
            @(negedge clk);
        end

        // Row 30 flushed, so the queue is empty and waiting for a PC.
        need_pc = 1'b1;
        mpc     = '0;
        for (int c = 0; c < 3000; c++) begin
            ev = 1'b0; erv = 1'b0; ef = 1'b0; ed = '0; n = 0;
            if (mq.size() >= 1) begin
                pl = mq[0];
                if (pl.f) begin
                    ev = 1'b1; erv = 1'b1; ef = 1'b1; n = 1;
                end else if (pl.d[1:0] != 2'b11) begin
                    ev = 1'b1; erv = 1'b1; ed = {16'h0000, pl.d}; n = 1;
                end else if (mq.size() >= 2) begin
                    ev = 1'b1; ed = {mq[1].d, pl.d}; ef = mq[1].f; n = 2;
                end
            end
            er = ((PARCELS - mq.size()) >= FETCH_W / 16);
            check_outs($sformatf("rnd%0d", c), ev, er, mpc, ev, ed, erv, ef);

            flush_i      = ($urandom_range(0, 24) == 0);
            fe_valid_i   = ($urandom_range(0, 9) < 6);
            fe_pc_i      = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 | ($urandom() & 32'h6))
                                                      : ($urandom() & 32'hFFFFFFFE);
            fe_data_i    = FETCH_W'($urandom());
            fe_fault_i   = ($urandom_range(0, 9) == 0);
            inst_ready_i = ($urandom_range(0, 9) < 6);

            if (flush_i) begin
                mq.delete();
                need_pc = 1'b1;
            end else begin
                if (ev && inst_ready_i) begin
                    for (int k = 0; k < n; k++) void'(mq.pop_front());
                    mpc = mpc + 32'(2 * n);
                end
                if (fe_valid_i && er) begin
                    off = need_pc ? int'((fe_pc_i % (FETCH_W / 8)) / 2) : 0;
                    for (int k = off; k < FETCH_W / 16; k++) begin
                        pl.d = fe_data_i[16*k +: 16];
                        pl.f = fe_fault_i;
                        mq.push_back(pl);
                    end
                    if (need_pc) begin
                        mpc     = fe_pc_i;
                        need_pc = 1'b0;
                    end
                end
            end
            @(negedge clk);
        end

        // Reset wins over a simultaneous flush, push and pop.
        rst = 1'b1;
        drive(1, 1, 32'h00000600, 32'h00000413, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 32'h0, '0, 0, 0);
        check_outs("reset_override", 1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
